// File: rtl/nco_quad_chirp.sv
// Quadrature NCO with linear up/down chirp and a quarter-wave sine table.
// Latency 3 cycles from en to out_valid, one sample per clock; no backpressure (en is a pure strobe).
module nco_quad_chirp #(
  parameter int PHASE_W    = 25,
  parameter int LUT_ADDR_W = 10,
  parameter int OUT_W      = 13
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [PHASE_W-1:0]        freq_init,
  input  logic [PHASE_W-1:0]        chirp_step,
  input  logic                      en,
  output logic signed [OUT_W-1:0]   sin_out,
  output logic signed [OUT_W-1:0]   cos_out,
  output logic                      out_valid
);

  localparam int LUT_N = 1 << LUT_ADDR_W;
  localparam int AMP   = (1 << (OUT_W - 1)) - 1;

  // Elaboration-time sine via Taylor series; sampled at bin centres so the
  // table is symmetric and never reaches the negative full-scale code.
  function automatic int lut_calc(input int k);
    real x, term, acc;
    x    = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(LUT_N);
    term = x;
    acc  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return $rtoi(real'(AMP) * acc + 0.5);
  endfunction

  logic [OUT_W-2:0] lut [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam int V = lut_calc(k);
    assign lut[k] = (OUT_W-1)'(V);
  end

  function automatic logic [PHASE_W-1:0] freq_next(input logic [PHASE_W-1:0] f,
                                                   input logic [1:0]         m,
                                                   input logic [PHASE_W-1:0] s);
    case (m)
      2'b01:   return f + s;
      2'b10:   return f - s;
      default: return f;
    endcase
  endfunction

  logic [PHASE_W-1:0]    phase, freq, step;
  logic [1:0]            cmode;
  logic                  v1, v2;
  logic [PHASE_W-1:0]    ph1;
  logic [1:0]            q2;
  logic [LUT_ADDR_W-1:0] sa2, ca2;

  logic [1:0]            quad1;
  logic [LUT_ADDR_W-1:0] idx1;
  logic                  unused_low;

  assign quad1      = ph1[PHASE_W-1 -: 2];
  assign idx1       = ph1[PHASE_W-3 -: LUT_ADDR_W];
  assign unused_low = ^ph1[PHASE_W-3-LUT_ADDR_W:0];

  logic signed [OUT_W-1:0] smag, cmag;

  assign smag = $signed({1'b0, lut[sa2]});
  assign cmag = $signed({1'b0, lut[ca2]});

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= '0;
      freq      <= '0;
      step      <= '0;
      cmode     <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      ph1       <= '0;
      q2        <= '0;
      sa2       <= '0;
      ca2       <= '0;
      sin_out   <= '0;
      cos_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      // Stage 1: accumulate; start restarts from phase 0 with the new config.
      v1 <= en;
      if (en) ph1 <= start ? '0 : phase;
      if (start) begin
        step  <= chirp_step;
        cmode <= mode;
        phase <= en ? freq_init : '0;
        freq  <= en ? freq_next(freq_init, mode, chirp_step) : freq_init;
      end else if (en) begin
        phase <= phase + freq;
        freq  <= freq_next(freq, cmode, step);
      end

      // Stage 2: odd quadrants read the table mirrored.
      v2 <= v1;
      if (v1) begin
        q2  <= quad1;
        sa2 <= quad1[0] ? ~idx1 : idx1;
        ca2 <= quad1[0] ? idx1 : ~idx1;
      end

      // Stage 3: sine negative in the lower half, cosine in quadrants 1 and 2.
      out_valid <= v2;
      if (v2) begin
        sin_out <= q2[1] ? -smag : smag;
        cos_out <= (q2[1] ^ q2[0]) ? -cmag : cmag;
      end
    end
  end

endmodule

// File: tb/tb_nco_quad_chirp.sv
// Randomised and directed bench for nco_quad_chirp against a table/queue reference model.
module tb_nco_quad_chirp;

  localparam int PW = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, start, en;
  logic [1:0]           mode;
  logic [PW-1:0]        freq_init, chirp_step;
  logic signed [12:0]   sin_out, cos_out;
  logic                 out_valid;

  nco_quad_chirp dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .freq_init  (freq_init),
    .chirp_step (chirp_step),
    .en         (en),
    .sin_out    (sin_out),
    .cos_out    (cos_out),
    .out_valid  (out_valid)
  );

  int total = 0;
  int bad   = 0;

  int tbl [1024];

  typedef struct {
    int      due;
    bit [24:0] ph;
  } smp_t;
  smp_t pend[$];

  bit [24:0] m_phase, m_freq, m_step;
  bit [1:0]  m_mode;
  int        cyc = 0;
  int        last_s = 0, last_c = 0;
  int        log_s[$], log_c[$];
  bit        pwr_chk = 1'b0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit [24:0] chirp(input bit [24:0] f, input bit [1:0] md, input bit [24:0] s);
    if (md == 2'd1) return f + s;
    if (md == 2'd2) return f - s;
    return f;
  endfunction

  function automatic void refval(input bit [24:0] p, output int s, output int c);
    int q, i, ni;
    q  = int'(p / (1 << 23));
    i  = int'((p / (1 << 13)) % 1024);
    ni = 1023 - i;
    case (q)
      0:       begin s =  tbl[i];  c =  tbl[ni]; end
      1:       begin s =  tbl[ni]; c = -tbl[i];  end
      2:       begin s = -tbl[i];  c = -tbl[ni]; end
      default: begin s = -tbl[ni]; c =  tbl[i];  end
    endcase
  endfunction

  task automatic cycle(input bit r, input bit s, input bit [1:0] md,
                       input bit [24:0] fi, input bit [24:0] cs, input bit e);
    bit [24:0] cap;
    smp_t      t;
    int        es, ec, si, ci;
    real       pw;
    cap = '0;
    rst = r; start = s; mode = md; freq_init = fi; chirp_step = cs; en = e;
    @(posedge clk);
    if (r) begin
      m_phase = '0; m_freq = '0; m_step = '0; m_mode = '0;
      pend.delete();
      last_s = 0; last_c = 0;
    end else begin
      if (s) begin
        m_mode = md; m_step = cs; m_phase = '0; m_freq = fi;
      end
      if (e) begin
        cap   = m_phase;
        t.due = cyc + 3;
        t.ph  = cap;
        pend.push_back(t);
        m_phase = m_phase + m_freq;
        m_freq  = chirp(m_freq, m_mode, m_step);
      end
    end
    cyc++;
    #1;
    if (!r && e) chk("captured_phase", dut.ph1, cap);
    chk("phase", dut.phase, m_phase);
    chk("freq", dut.freq, m_freq);
    if (pend.size() > 0 && pend[0].due == cyc) begin
      refval(pend[0].ph, es, ec);
      void'(pend.pop_front());
      chk("out_valid", out_valid, 1);
      chk("sin", sin_out, es);
      chk("cos", cos_out, ec);
      last_s = es; last_c = ec;
      si = sin_out; ci = cos_out;
      log_s.push_back(si); log_c.push_back(ci);
      if (pwr_chk) begin
        pw = real'(si) * real'(si) + real'(ci) * real'(ci);
        chk("power", (pw >= 4095.0 * 4095.0 * 0.999 && pw <= 4095.0 * 4095.0 * 1.001) ? 1 : 0, 1);
      end
    end else begin
      chk("out_valid_idle", out_valid, 0);
      chk("sin_hold", sin_out, last_s);
      chk("cos_hold", cos_out, last_c);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 2'd0, '0, '0, 0);
  endtask

  initial begin
    for (int k = 0; k < 1024; k++)
      tbl[k] = $rtoi(4095.0 * $sin(3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / 1024.0) + 0.5);

    // Reset, then en without any start: phase 0, fixed, freq 0.
    cycle(1, 0, 2'd0, '0, '0, 0);
    cycle(1, 1, 2'd1, 25'd77, 25'd3, 1);
    log_s.delete(); log_c.delete();
    cycle(0, 0, 2'd0, '0, '0, 1);
    cycle(0, 0, 2'd0, '0, '0, 1);
    idle(3);
    chk("noinit_sin", log_s[0], 3);
    chk("noinit_cos", log_c[0], 4095);

    // Quarter-turn steps.
    log_s.delete(); log_c.delete();
    cycle(0, 1, 2'd0, 25'd1 << 23, '0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 0, 2'd0, '0, '0, 1);
    idle(3);
    chk("quad_s0", log_s[0], 3);     chk("quad_c0", log_c[0], 4095);
    chk("quad_s1", log_s[1], 4095);  chk("quad_c1", log_c[1], -3);
    chk("quad_s2", log_s[2], -3);    chk("quad_c2", log_c[2], -4095);
    chk("quad_s3", log_s[3], -4095); chk("quad_c3", log_c[3], 3);

    // Up-chirp from zero.
    cycle(0, 1, 2'd1, '0, 25'd1, 0);
    for (int k = 0; k < 5; k++) cycle(0, 0, 2'd0, '0, '0, 1);
    chk("upchirp_freq", dut.freq, 5);
    idle(3);

    // Frequency wrap up and down.
    cycle(0, 1, 2'd1, 25'h1FF_FFFF, 25'd1, 0);
    cycle(0, 0, 2'd0, '0, '0, 1);
    chk("wrap_up0", dut.freq, 0);
    cycle(0, 0, 2'd0, '0, '0, 1);
    chk("wrap_up1", dut.freq, 1);
    cycle(0, 1, 2'd2, '0, 25'd1, 0);
    cycle(0, 0, 2'd0, '0, '0, 1);
    chk("wrap_down", dut.freq, 32'h1FF_FFFF);
    idle(3);

    // Gapped strobe.
    cycle(0, 1, 2'd0, 25'd1 << 23, '0, 0);
    cycle(0, 0, 2'd0, '0, '0, 1);
    cycle(0, 0, 2'd0, '0, '0, 0);
    cycle(0, 0, 2'd0, '0, '0, 1);
    cycle(0, 0, 2'd0, '0, '0, 1);
    cycle(0, 0, 2'd0, '0, '0, 0);
    idle(4);

    // start together with en mid-stream.
    log_s.delete(); log_c.delete();
    cycle(0, 0, 2'd0, '0, '0, 1);
    cycle(0, 0, 2'd0, '0, '0, 1);
    cycle(0, 1, 2'd1, 25'd1 << 22, 25'd5, 1);
    idle(4);
    chk("prio_sin", log_s[2], 3);
    chk("prio_cos", log_c[2], 4095);

    // Reset one cycle after en discards the sample.
    cycle(0, 0, 2'd0, '0, '0, 1);
    cycle(1, 0, 2'd0, '0, '0, 0);
    idle(4);
    chk("rst_sin", sin_out, 0);
    chk("rst_cos", cos_out, 0);

    // Random traffic.
    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 79) == 0, $urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)),
            25'($urandom), 25'($urandom), $urandom_range(0, 3) != 0);
    idle(3);

    // Full-circle sweep, one table entry per sample.
    cycle(0, 1, 2'd0, 25'd1 << 13, '0, 0);
    pwr_chk = 1'b1;
    for (int k = 0; k < 4096; k++) cycle(0, 0, 2'd0, '0, '0, 1);
    idle(3);
    pwr_chk = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
